fsm_decoder: RTL and testbench

Receive-side counterpart of the team's rate-1/2, 4-state Mealy bit encoder: accepts one 2-bit code symbol per handshake, inverts the encoder trellis to recover the original serial bit, and assembles recovered bits MSB-first into DATA_W-bit words. Detects symbols illegal for the tracked encoder state, counts them, and holds in an error state until resynchronised. Sits between the symbol channel and the byte-oriented consumer.

---
 rtl/fsm_codec_pkg.sv | 23 ++
 rtl/fsm_trellis_step.sv | 20 ++
 rtl/fsm_decoder.sv | 103 ++++++++++
 tb/tb_fsm_decoder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_codec_pkg.sv
// Shared trellis definition for the rate-1/2, 4-state Mealy bit encoder and its decoder.
// Both sides call enc_out/enc_next so the trellis is defined only once.
package fsm_codec_pkg;

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } ctrl_state_t;

    typedef logic [1:0] enc_state_t;

    localparam enc_state_t ENC_RESET = 2'b00;

    // Code symbol {y1,y0} emitted for input bit x from encoder state s = {b1,b0}
    function automatic logic [1:0] enc_out(input enc_state_t s, input logic x);
        return {x ^ s[1] ^ s[0], x ^ s[0]};
    endfunction

    function automatic enc_state_t enc_next(input enc_state_t s, input logic x);
        return {x, s[1]};
    endfunction

endpackage

// File: rtl/fsm_trellis_step.sv
// One inverse-trellis step: recover the input bit from a symbol and check it
// against the encoder state being tracked.
module fsm_trellis_step
    import fsm_codec_pkg::*;
(
    input  enc_state_t  s,
    input  logic [1:0]  sym,
    output logic        x,
    output logic        legal,
    output enc_state_t  s_next
);

    // y0 alone determines x; y1 is then redundant and serves as the check bit
    always_comb begin
        x      = sym[0] ^ s[0];
        legal  = (sym == enc_out(s, x));
        s_next = enc_next(s, x);
    end

endmodule

// File: rtl/fsm_decoder.sv
// Symbol-channel decoder: inverts the encoder trellis, assembles recovered bits
// MSB-first into words, and parks in ERR on an illegal symbol until resync.
module fsm_decoder
    import fsm_codec_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sym_valid,
    input  logic [1:0]        sym,
    input  logic              resync,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    ctrl_state_t         state, state_d;
    enc_state_t          s, s_d, s_next;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [DATA_W-2:0]   shreg, shreg_d;
    logic [DATA_W-1:0]   data_d;
    logic                dv_d;
    logic [ERR_W-1:0]    errc_d;
    logic                x, legal;

    fsm_trellis_step u_step (
        .s      (s),
        .sym    (sym),
        .x      (x),
        .legal  (legal),
        .s_next (s_next)
    );

    // Register stage: control state, tracked encoder state, word assembly, outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            s          <= ENC_RESET;
            cnt        <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            err        <= 1'b0;
            err_count  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            s          <= s_d;
            cnt        <= cnt_d;
            shreg      <= shreg_d;
            data       <= data_d;
            data_valid <= dv_d;
            err        <= (state_d == ERR);
            err_count  <= errc_d;
            busy       <= (cnt_d != '0);
        end
    end

    // Next-state: resync dominates any symbol arriving in the same cycle
    always_comb begin
        state_d = state;
        s_d     = s;
        cnt_d   = cnt;
        shreg_d = shreg;
        data_d  = data;
        dv_d    = 1'b0;
        errc_d  = err_count;

        if (resync) begin
            state_d = RUN;
            s_d     = ENC_RESET;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (sym_valid && (state == RUN)) begin
            if (legal) begin
                s_d = s_next;
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    data_d  = {shreg, x};
                    dv_d    = 1'b1;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    shreg_d = {shreg[DATA_W-3:0], x};
                    cnt_d   = cnt + CNT_W'(1);
                end
            end else begin
                state_d = ERR;
                cnt_d   = '0;
                shreg_d = '0;
                if (err_count != '1) begin
                    errc_d = err_count + ERR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fsm_decoder.sv
// Directed bench for fsm_decoder using hand-encoded symbol streams.
module tb_fsm_decoder;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ERR_W  = 8;

    logic              clk;
    logic              rst;
    logic              sym_valid;
    logic [1:0]        sym;
    logic              resync;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              err;
    logic [ERR_W-1:0]  err_count;
    logic              busy;

    fsm_decoder #(.DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sym_valid  (sym_valid),
        .sym        (sym),
        .resync     (resync),
        .data       (data),
        .data_valid (data_valid),
        .err        (err),
        .err_count  (err_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int pulses = 0;
    logic [DATA_W-1:0] words[$];

    // 0xA5 encoded from state 00 (ends in state 10)
    logic [1:0] a5_syms [8] = '{2'b11, 2'b10, 2'b00, 2'b10, 2'b11, 2'b11, 2'b10, 2'b00};
    // 0x3C encoded from state 10 (ends in state 00)
    logic [1:0] c3_syms [8] = '{2'b10, 2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
    logic [1:0] both_syms [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge
    task automatic cyc(input logic v, input logic [1:0] sy, input logic r);
        @(negedge clk);
        sym_valid = v;
        sym       = sy;
        resync    = r;
        @(posedge clk);
        #1;
        if (data_valid === 1'b1) begin
            pulses++;
            words.push_back(data);
        end
    endtask

    task automatic send_a5();
        for (int i = 0; i < 8; i++) cyc(1'b1, a5_syms[i], 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        sym_valid = 1'b0;
        resync = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int idx;
        rst = 1'b0;
        sym_valid = 1'b0;
        sym = 2'b00;
        resync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            both_syms[i]     = a5_syms[i];
            both_syms[i + 8] = c3_syms[i];
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_dv", 32'(data_valid), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_errc", 32'(err_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Clean 0xA5 word: busy through bits 1-7, single pulse on bit 8
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, a5_syms[i], 1'b0);
            chk($sformatf("t1_busy_%0d", i), 32'(busy), (i < 7) ? 32'h1 : 32'h0);
            chk($sformatf("t1_dv_%0d", i), 32'(data_valid), (i == 7) ? 32'h1 : 32'h0);
        end
        chk("t1_data", 32'(data), 32'hA5);
        chk("t1_err", 32'(err), 32'h0);
        cyc(1'b0, 2'b00, 1'b0);
        chk("t1_dv_drop", 32'(data_valid), 32'h0);
        chk("t1_data_hold", 32'(data), 32'hA5);

        // Illegal symbol, ignored symbols while in ERR, then resync
        do_reset();
        pulses = 0;
        cyc(1'b1, 2'b01, 1'b0);
        chk("t2_err", 32'(err), 32'h1);
        chk("t2_errc", 32'(err_count), 32'h1);
        chk("t2_busy", 32'(busy), 32'h0);
        send_a5();
        chk("t2_ign_pulses", 32'(pulses), 32'h0);
        chk("t2_ign_err", 32'(err), 32'h1);
        chk("t2_ign_errc", 32'(err_count), 32'h1);
        cyc(1'b0, 2'b00, 1'b1);
        chk("t2_rs_err", 32'(err), 32'h0);
        chk("t2_rs_errc", 32'(err_count), 32'h1);
        words.delete();
        send_a5();
        chk("t2_pulses", 32'(pulses), 32'h1);
        chk("t2_data", 32'(data), 32'hA5);

        // Asynchronous reset mid-word
        cyc(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, a5_syms[i], 1'b0);
        chk("t3_busy_pre", 32'(busy), 32'h1);
        @(negedge clk);
        sym_valid = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("t3_data", 32'(data), 32'h0);
        chk("t3_dv", 32'(data_valid), 32'h0);
        chk("t3_err", 32'(err), 32'h0);
        chk("t3_errc", 32'(err_count), 32'h0);
        chk("t3_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        send_a5();
        cyc(1'b0, 2'b00, 1'b0);
        chk("t3_pulses", 32'(pulses), 32'h1);
        chk("t3_data_after", 32'(data), 32'hA5);

        // Two words with sym_valid gaps inserted at random
        cyc(1'b0, 2'b00, 1'b1);
        pulses = 0;
        words.delete();
        idx = 0;
        for (int n = 0; n < 200 && idx < 16; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                cyc(1'b1, both_syms[idx], 1'b0);
                idx++;
            end else begin
                cyc(1'b0, 2'($urandom), 1'b0);
            end
        end
        repeat (2) cyc(1'b0, 2'b00, 1'b0);
        chk("t4_pulses", 32'(pulses), 32'h2);
        chk("t4_words", 32'(words.size()), 32'h2);
        if (words.size() == 2) begin
            chk("t4_word0", 32'(words[0]), 32'hA5);
            chk("t4_word1", 32'(words[1]), 32'h3C);
        end
        chk("t4_err", 32'(err), 32'h0);

        // resync collides with a valid symbol mid-word
        pulses = 0;
        for (int i = 0; i < 3; i++) cyc(1'b1, a5_syms[i], 1'b0);
        cyc(1'b1, a5_syms[3], 1'b1);
        chk("t5_busy", 32'(busy), 32'h0);
        chk("t5_err", 32'(err), 32'h0);
        send_a5();
        chk("t5_pulses", 32'(pulses), 32'h1);
        chk("t5_data", 32'(data), 32'hA5);

        // Error counter saturation
        cyc(1'b0, 2'b00, 1'b1);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 2'b01, 1'b0);
            if (i == 100) chk("t6_errc_mid", 32'(err_count), 32'd101);
            cyc(1'b0, 2'b00, 1'b1);
        end
        chk("t6_errc_sat", 32'(err_count), 32'd255);
        chk("t6_err", 32'(err), 32'h0);
        cyc(1'b1, 2'b01, 1'b0);
        chk("t6_errc_hold", 32'(err_count), 32'd255);
        chk("t6_err_set", 32'(err), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
